// File: rtl/vga_rx_capture.sv
// vga_rx_capture: VGA timing receiver. Registers the sync/valid/data pins, measures
// the line and frame geometry, locks after two identical frames and then emits one
// (x, y, data) write strobe per active pixel for a frame buffer.
module vga_rx_capture #(
    parameter int DATA_W     = 24,
    parameter int CW         = 11,
    parameter int MIN_HTOTAL = 100,
    parameter int MIN_VTOTAL = 10
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              pix_we,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_start,
    output logic              locked,
    output logic              err,
    output logic [CW-1:0]     h_total,
    output logic [CW-1:0]     h_active,
    output logic [CW-1:0]     v_total,
    output logic [CW-1:0]     v_active
);

    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [CW-1:0] MIN_H = CW'(MIN_HTOTAL);
    localparam logic [CW-1:0] MIN_V = CW'(MIN_VTOTAL);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_VERIFY, ST_LOCKED} state_t;

    state_t state, state_nx;

    // input stage A plus stage B delay for edge detection
    logic              hs_a, hs_b, vs_a, vs_b, vld_a, vld_b;
    logic [DATA_W-1:0] dat_a;

    // running counters
    logic [CW-1:0] lcnt, acnt, rcnt, arcnt;
    // last completed line length / last non-empty line's valid count in this frame
    logic [CW-1:0] lline, lact;
    // snapshot of the previous frame
    logic [CW-1:0] s_h, s_a, s_v, s_va;

    logic          hfall, vfall, vld_fall;
    logic [CW-1:0] lcnt_nx, acnt_nx, rcnt_eff, arcnt_eff, line_eff, act_eff;
    logic          sat_any, h_bad, v_bad, frame_eq, geom_ok, lock_ok;
    logic          err_nx, latch_s, publish;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    assign hfall    = hs_b & ~hs_a;
    assign vfall    = vs_b & ~vs_a;
    assign vld_fall = vld_b & ~vld_a;

    // counter next values; the "eff" terms fold in a same-cycle hsync/valid event so
    // the frame-level check at vsync fall sees the hsync update first
    always_comb begin
        lcnt_nx   = hfall ? CW'(1) : sat_inc(lcnt);
        if (hfall)
            acnt_nx = vld_a ? CW'(1) : '0;
        else
            acnt_nx = vld_a ? sat_inc(acnt) : acnt;
        rcnt_eff  = hfall ? sat_inc(rcnt) : rcnt;
        arcnt_eff = vld_fall ? sat_inc(arcnt) : arcnt;
        line_eff  = hfall ? lcnt : lline;
        act_eff   = (hfall && acnt != '0) ? acnt : lact;
        sat_any   = (lcnt == CMAX) | (acnt == CMAX) | (rcnt == CMAX) | (arcnt == CMAX);
        h_bad     = hfall && ((lcnt != h_total) || (acnt != '0 && acnt != h_active));
        v_bad     = vfall && ((rcnt_eff != v_total) || (arcnt_eff != v_active));
        frame_eq  = (line_eff == s_h) && (act_eff == s_a) &&
                    (rcnt_eff == s_v) && (arcnt_eff == s_va);
        geom_ok   = (line_eff >= MIN_H) && (rcnt_eff >= MIN_V);
        lock_ok   = frame_eq && geom_ok && !sat_any;
    end

    // state register
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) state <= ST_SEARCH;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_SEARCH:  if (vfall) state_nx = ST_MEASURE;
            ST_MEASURE: if (vfall) state_nx = ST_VERIFY;
            ST_VERIFY:  if (vfall && lock_ok) state_nx = ST_LOCKED;
            ST_LOCKED:  if (h_bad || v_bad || sat_any) state_nx = ST_SEARCH;
            default:    state_nx = ST_SEARCH;
        endcase
    end

    // FSM outputs: error pulse request, snapshot latch, publish of measurements
    always_comb begin
        err_nx  = 1'b0;
        latch_s = 1'b0;
        publish = 1'b0;
        case (state)
            ST_MEASURE: latch_s = vfall;
            ST_VERIFY: begin
                if (vfall) begin
                    if (lock_ok) begin
                        publish = 1'b1;
                    end else begin
                        latch_s = 1'b1;
                        err_nx  = !geom_ok;
                    end
                end
            end
            ST_LOCKED:  err_nx = h_bad | v_bad | sat_any;
            default: ;
        endcase
    end

    assign locked = (state == ST_LOCKED);

    // input sampling stages
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_a  <= 1'b0;
            hs_b  <= 1'b0;
            vs_a  <= 1'b0;
            vs_b  <= 1'b0;
            vld_a <= 1'b0;
            vld_b <= 1'b0;
            dat_a <= '0;
        end else begin
            hs_a  <= hsync_in;
            hs_b  <= hs_a;
            vs_a  <= vsync_in;
            vs_b  <= vs_a;
            vld_a <= valid_in;
            vld_b <= vld_a;
            dat_a <= data_in;
        end
    end

    // geometry counters and frame snapshot
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            lcnt  <= '0;
            acnt  <= '0;
            rcnt  <= '0;
            arcnt <= '0;
            lline <= '0;
            lact  <= '0;
            s_h   <= '0;
            s_a   <= '0;
            s_v   <= '0;
            s_va  <= '0;
        end else begin
            lcnt  <= lcnt_nx;
            acnt  <= acnt_nx;
            rcnt  <= vfall ? '0 : rcnt_eff;
            arcnt <= vfall ? '0 : arcnt_eff;
            lline <= vfall ? '0 : line_eff;
            lact  <= vfall ? '0 : act_eff;
            if (latch_s) begin
                s_h  <= line_eff;
                s_a  <= act_eff;
                s_v  <= rcnt_eff;
                s_va <= arcnt_eff;
            end
        end
    end

    // registered outputs: pixel strobe, coordinates, pulses and published geometry
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            pix_we      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
        end else begin
            // gate with next state so a strobe never appears without locked
            pix_we      <= vld_a && (state_nx == ST_LOCKED);
            pix_x       <= hfall ? '0 : acnt[9:0];
            pix_y       <= arcnt[9:0];
            pix_data    <= dat_a;
            frame_start <= vfall;
            err         <= err_nx;
            if (publish) begin
                h_total  <= line_eff;
                h_active <= act_eff;
                v_total  <= rcnt_eff;
                v_active <= arcnt_eff;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture using a reduced 120x14 timing
// (hsync low cols 1..8, vsync low lines 1..2, valid cols 21..84, rows 4..11).
module tb_vga_rx_capture;

    localparam int DW   = 24;
    localparam int CW   = 11;
    localparam int HT   = 120;
    localparam int VT   = 14;
    localparam int HS_W = 8;
    localparam int VS_W = 2;
    localparam int X0   = 21;
    localparam int XA   = 64;
    localparam int Y0   = 4;
    localparam int YA   = 8;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          hsync_in = 1'b1, vsync_in = 1'b1, valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pix_we, frame_start, locked, err;
    logic [9:0]    pix_x, pix_y;
    logic [DW-1:0] pix_data;
    logic [CW-1:0] h_total, h_active, v_total, v_active;

    vga_rx_capture #(.DATA_W(DW), .CW(CW), .MIN_HTOTAL(100), .MIN_VTOTAL(10)) dut (
        .pclk(pclk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .valid_in(valid_in), .data_in(data_in), .pix_we(pix_we), .pix_x(pix_x),
        .pix_y(pix_y), .pix_data(pix_data), .frame_start(frame_start), .locked(locked),
        .err(err), .h_total(h_total), .h_active(h_active), .v_total(v_total),
        .v_active(v_active)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // one-cycle expectation pipeline (outputs lag the driven input by one edge)
    logic          prev_we = 1'b0;
    logic [9:0]    prev_x = '0, prev_y = '0;
    logic [DW-1:0] prev_d = '0;

    int   we_cnt, err_cnt, lk_cnt, fs_cnt;
    logic lk1, lk2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic hs, input logic vs, input logic vld,
                        input logic [DW-1:0] d, input logic ew,
                        input logic [9:0] x, input logic [9:0] y);
        hsync_in = hs;
        vsync_in = vs;
        valid_in = vld;
        data_in  = d;
        @(posedge pclk);
        #1;
        chk("pix_we", 32'(pix_we), 32'(prev_we));
        if (prev_we) begin
            chk("pix_x", 32'(pix_x), 32'(prev_x));
            chk("pix_y", 32'(pix_y), 32'(prev_y));
            chk("pix_data", 32'(pix_data), 32'(prev_d));
        end
        if (pix_we === 1'b1)      we_cnt++;
        if (err === 1'b1)         err_cnt++;
        if (locked === 1'b1)      lk_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        prev_we = ew;
        prev_x  = x;
        prev_y  = y;
        prev_d  = d;
    endtask

    // nl lines of hl cycles; line short_l is one cycle short; cap = strobes expected;
    // abort_l > 0 returns mid-line (col 50) of that line
    task automatic run_frame(input int nl, input int hl, input int short_l,
                             input bit cap, input int abort_l);
        logic          vld, ew;
        logic [9:0]    xv, yv;
        logic [DW-1:0] d;
        int            len;
        we_cnt = 0; err_cnt = 0; lk_cnt = 0; fs_cnt = 0;
        lk1 = 1'b0; lk2 = 1'b0;
        for (int l = 1; l <= nl; l++) begin
            len = (l == short_l) ? hl - 1 : hl;
            for (int c = 1; c <= len; c++) begin
                if (l == abort_l && c == 50) return;
                vld = (l >= Y0) && (l < Y0 + YA) && (c >= X0) && (c < X0 + XA) && (c <= hl);
                xv  = 10'(c - X0);
                yv  = 10'(l - Y0);
                d   = vld ? {yv[7:0], xv[7:0], 8'hA5} : '0;
                ew  = vld && cap && !(short_l > 0 && l > short_l);
                step(c > HS_W, l > VS_W, vld, d, ew, xv, yv);
                if (l == 1 && c == 1) lk1 = locked;
                if (l == 1 && c == 2) lk2 = locked;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pix_we", 32'(pix_we), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_h_total", 32'(h_total), 0);
        chk("rst_v_total", 32'(v_total), 0);
        reset = 1'b0;
        idle(6);

        // acquisition: two uncaptured frames, lock one cycle after the third vsync fall
        run_frame(VT, HT, 0, 1'b0, 0);
        chk("f0_frame_start", 32'(fs_cnt), 1);
        chk("f0_locked", 32'(lk_cnt), 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        chk("f1_locked", 32'(lk_cnt), 0);
        run_frame(VT, HT, 0, 1'b1, 0);
        chk("lock_edge0", 32'(lk1), 0);
        chk("lock_edge1", 32'(lk2), 1);
        chk("f2_we_cnt", 32'(we_cnt), XA * YA);
        chk("f2_err", 32'(err_cnt), 0);
        chk("h_total", 32'(h_total), HT);
        chk("h_active", 32'(h_active), XA);
        chk("v_total", 32'(v_total), VT);
        chk("v_active", 32'(v_active), YA);
        run_frame(VT, HT, 0, 1'b1, 0);
        chk("f3_we_cnt", 32'(we_cnt), XA * YA);

        // one short line: err at its end, rows 0..2 captured, relock after 3 vsync falls
        run_frame(VT, HT, 6, 1'b1, 0);
        chk("short_err", 32'(err_cnt), 1);
        chk("short_we_cnt", 32'(we_cnt), XA * 3);
        chk("short_locked", 32'(locked), 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        chk("short_relock_we", 32'(we_cnt), 0);
        run_frame(VT, HT, 0, 1'b1, 0);
        chk("short_relock", 32'(lk2), 1);
        chk("short_relock_we_cnt", 32'(we_cnt), XA * YA);

        // one frame with a missing line: err at the following vsync fall
        run_frame(VT - 1, HT, 0, 1'b1, 0);
        chk("drop_we_cnt", 32'(we_cnt), XA * YA);
        chk("drop_no_err_yet", 32'(err_cnt), 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        chk("drop_err", 32'(err_cnt), 1);
        chk("drop_unlocked", 32'(lk2), 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        chk("drop_no_we", 32'(we_cnt), 0);
        run_frame(VT, HT, 0, 1'b1, 0);
        chk("drop_relock", 32'(lk2), 1);
        chk("drop_relock_we_cnt", 32'(we_cnt), XA * YA);

        // reset in the middle of an active line
        run_frame(VT, HT, 0, 1'b1, 6);
        chk("pre_rst_pix_we", 32'(pix_we), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pix_we", 32'(pix_we), 0);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_pix_x", 32'(pix_x), 0);
        chk("mid_rst_pix_data", 32'(pix_data), 0);
        chk("mid_rst_h_total", 32'(h_total), 0);
        chk("mid_rst_v_active", 32'(v_active), 0);
        repeat (2) @(posedge pclk);
        #1;
        reset   = 1'b0;
        prev_we = 1'b0;
        idle(10);
        run_frame(VT, HT, 0, 1'b0, 0);
        run_frame(VT, HT, 0, 1'b0, 0);
        chk("rst_no_we", 32'(we_cnt), 0);
        run_frame(VT, HT, 0, 1'b1, 0);
        chk("rst_relock", 32'(lk2), 1);
        chk("rst_relock_we_cnt", 32'(we_cnt), XA * YA);

        // 50-cycle lines: first line-length check drops lock, never relocks
        run_frame(VT, 50, 0, 1'b0, 0);
        chk("short_h_err", 32'(err_cnt), 1);
        for (int f = 0; f < 4; f++) begin
            run_frame(VT, 50, 0, 1'b0, 0);
            chk("minh_locked", 32'(lk_cnt), 0);
            chk("minh_we", 32'(we_cnt), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
